// File: rtl/updown_counter_param_if.sv
// Bus bundle for updown_counter_param.
// master: drives the controls (en, load, data_in, up, down, step, limit, sat)
//         and receives the status (count, tc_max, tc_min, ovf, unf).
// slave : the counter side of the same signals.
interface updown_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             up;
  logic             down;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic             sat;
  logic [WIDTH-1:0] count;
  logic             tc_max;
  logic             tc_min;
  logic             ovf;
  logic             unf;

  modport master (
    output en, load, data_in, up, down, step, limit, sat,
    input  count, tc_max, tc_min, ovf, unf
  );

  modport slave (
    input  en, load, data_in, up, down, step, limit, sat,
    output count, tc_max, tc_min, ovf, unf
  );
endinterface

// File: rtl/updown_counter_param.sv
// WIDTH-bit up/down counter with parallel load, count enable, programmable
// step and inclusive upper limit, wrap or saturate at the bounds.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (count, ovf, unf -> 0)
//   bus   - updown_counter_param_if.slave:
//           en/load/data_in/up/down/step/limit/sat in,
//           count (registered), tc_max/tc_min (combinational),
//           ovf/unf (registered one-cycle pulses) out
module updown_counter_param #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  updown_counter_param_if.slave   bus
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // One extra bit so the carry/borrow is never silently dropped.
  logic [WIDTH:0]   sum_w, diff_w;
  logic             do_up, do_dn, step_nz;

  assign sum_w   = {1'b0, cnt_q} + {1'b0, bus.step};
  assign diff_w  = {1'b0, cnt_q} - {1'b0, bus.step};
  assign step_nz = |bus.step;
  assign do_up   = bus.en & bus.up & ~bus.down & step_nz;
  assign do_dn   = bus.en & bus.down & ~bus.up & step_nz;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (bus.load) begin
      cnt_d = (bus.data_in > bus.limit) ? bus.limit : bus.data_in;
    end else if (do_up) begin
      // A count already above a lowered limit always lands here as overflow.
      if (sum_w <= {1'b0, bus.limit}) begin
        cnt_d = sum_w[WIDTH-1:0];
      end else begin
        ovf_d = 1'b1;
        cnt_d = bus.sat ? bus.limit : '0;
      end
    end else if (do_dn) begin
      if (diff_w[WIDTH]) begin
        unf_d = 1'b1;
        cnt_d = bus.sat ? '0 : bus.limit;
      end else if (diff_w[WIDTH-1:0] > bus.limit) begin
        // Count was above a lowered limit: pull back inside the range quietly.
        cnt_d = bus.limit;
      end else begin
        cnt_d = diff_w[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.count  = cnt_q;
  assign bus.ovf    = ovf_q;
  assign bus.unf    = unf_q;
  assign bus.tc_max = (cnt_q == bus.limit);
  assign bus.tc_min = (cnt_q == '0);

endmodule
